// File: rtl/seg7_bcd_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus, with per-digit stability filtering.
// Optional SEG7_CAP_ERRCNT_EN adds a saturating 8-bit err_cnt output counting erroneous samples.
module seg7_bcd_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            led,
    input  logic [DIGITS-1:0]     an,
    input  logic                  sample_en,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     valid,
    output logic                  update,
    output logic [DIGITS-1:0]     pat_err,
    output logic                  an_err
`ifdef SEG7_CAP_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} digState_e;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    // The decimal point is not part of the digit code.
    logic unusedLed0;
    assign unusedLed0 = led[0];

    logic [6:0]          ledQ;
    logic [DIGITS-1:0]   anQ;
    logic                enQ;

    digState_e           stateQ [DIGITS];
    digState_e           stateD [DIGITS];
    logic [3:0]          candQ  [DIGITS];
    logic [3:0]          candD  [DIGITS];
    logic [3:0]          countQ [DIGITS];
    logic [3:0]          countD [DIGITS];
    logic [4*DIGITS-1:0] bcdQ, bcdD;
    logic [DIGITS-1:0]   validQ, validD;
    logic                updateQ, updateD;
    logic [DIGITS-1:0]   patErrQ, patErrD;
    logic                anErrQ, anErrD;
    logic                anyErr;
    logic                decOk;
    logic [3:0]          decCode;
`ifdef SEG7_CAP_ERRCNT_EN
    logic [7:0]          errCntQ, errCntD;
`endif

    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        case ({seg, 1'b0})
            8'h10:   return {1'b1, 4'd0};
            8'hB6:   return {1'b1, 4'd1};
            8'h44:   return {1'b1, 4'd2};
            8'h24:   return {1'b1, 4'd3};
            8'hA2:   return {1'b1, 4'd4};
            8'h28:   return {1'b1, 4'd5};
            8'h08:   return {1'b1, 4'd6};
            8'hB4:   return {1'b1, 4'd7};
            8'h00:   return {1'b1, 4'd8};
            8'h20:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ledQ <= '1;
            anQ  <= '1;
            enQ  <= 1'b0;
        end else begin
            ledQ <= led[7:1];
            anQ  <= an;
            enQ  <= sample_en;
        end
    end

    always_comb begin
        stateD  = stateQ;
        candD   = candQ;
        countD  = countQ;
        bcdD    = bcdQ;
        validD  = validQ;
        updateD = 1'b0;
        patErrD = clr_err ? '0 : patErrQ;
        anErrD  = clr_err ? 1'b0 : anErrQ;
        anyErr  = 1'b0;
        {decOk, decCode} = decodeSeg(ledQ);

        if (enQ) begin
            if (!$onehot(~anQ)) begin
                anErrD = 1'b1;
                anyErr = 1'b1;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (!anQ[i]) begin
                        if (!decOk) begin
                            patErrD[i] = 1'b1;
                            anyErr     = 1'b1;
                            countD[i]  = 4'd0;
                            stateD[i]  = EMPTY;
                        end else begin
                            if (stateQ[i] != EMPTY && candQ[i] == decCode) begin
                                if (countQ[i] < STABLE)
                                    countD[i] = countQ[i] + 4'd1;
                            end else begin
                                candD[i]  = decCode;
                                countD[i] = 4'd1;
                            end
                            // A locked digit that keeps matching recommits its own value, which never pulses.
                            if (countD[i] == STABLE) begin
                                stateD[i]     = LOCKED;
                                bcdD[4*i +: 4] = candD[i];
                                validD[i]     = 1'b1;
                                updateD       = !validQ[i] || (bcdQ[4*i +: 4] != candD[i]);
                            end else begin
                                stateD[i] = TRACK;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef SEG7_CAP_ERRCNT_EN
    always_comb begin
        errCntD = clr_err ? 8'd0 : errCntQ;
        if (anyErr)
            errCntD = clr_err ? 8'd1 : ((errCntQ == 8'hFF) ? 8'hFF : errCntQ + 8'd1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                stateQ[i] <= EMPTY;
                candQ[i]  <= 4'd0;
                countQ[i] <= 4'd0;
            end
            bcdQ    <= '0;
            validQ  <= '0;
            updateQ <= 1'b0;
            patErrQ <= '0;
            anErrQ  <= 1'b0;
`ifdef SEG7_CAP_ERRCNT_EN
            errCntQ <= 8'd0;
`endif
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                stateQ[i] <= stateD[i];
                candQ[i]  <= candD[i];
                countQ[i] <= countD[i];
            end
            bcdQ    <= bcdD;
            validQ  <= validD;
            updateQ <= updateD;
            patErrQ <= patErrD;
            anErrQ  <= anErrD;
`ifdef SEG7_CAP_ERRCNT_EN
            errCntQ <= errCntD;
`endif
        end
    end

    assign bcd     = bcdQ;
    assign valid   = validQ;
    assign update  = updateQ;
    assign pat_err = patErrQ;
    assign an_err  = anErrQ;
`ifdef SEG7_CAP_ERRCNT_EN
    assign err_cnt = errCntQ;
`endif

endmodule

// File: doc/seg7_bcd_capture.md
Name: seg7_bcd_capture

Overview:
- Receive-side companion to the BCD-to-7-segment driver: monitors a multiplexed 7-segment bus (8-bit active-low segment pattern plus active-low digit anodes) and recovers the BCD digit shown on each position.
- Used for display loopback self-test and for reading external segment-driven displays back into the design.
- Filters each digit for stability, commits it to a per-digit register, and flags undecodable patterns.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CNT, 3, consecutive identical valid samples required before a digit is committed (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- led  input  8  segment pattern, active low, bit7=s0 ... bit0=s7.
- an  input  DIGITS  digit anodes, active low; exactly one low selects a digit.
- sample_en  input  1  qualify strobe; led/an sampled only when high.
- clr_err  input  1  clears sticky error flags.
- bcd  output  4*DIGITS  committed digits; digit i is bcd[4i+3:4i].
- valid  output  DIGITS  digit i has been committed at least once since reset.
- update  output  1  one-cycle pulse when any digit register changes value or first becomes valid.
- pat_err  output  DIGITS  sticky; digit i received an undecodable pattern.
- an_err  output  1  sticky; a qualified sample had an anode that was not one-hot-low.

Behaviour:
- Reset (synchronous, active-high, rst sampled at clk edge): outputs and all internal state go to the following values.
  - bcd=0, valid=0, update=0, pat_err=0, an_err=0.
  - Every per-digit FSM goes to EMPTY with count=0.
- Stage 1 (input register): led, an and sample_en are registered every cycle.
- Stage 2 (decode/filter): operates on the stage-1 registers.
  - Latency: a sample presented before edge k takes effect at edge k+1.
- Decode table (led[7:1]; led[0] ignored):
  - 0x10→0, 0xB6→1, 0x44→2, 0x24→3, 0xA2→4, 0x28→5, 0x08→6, 0xB4→7, 0x00→8, 0x20→9.
  - Comparison uses led[7:1] only.
  - Any other pattern is invalid.
- Non-one-hot anode (including all-high) on a qualified sample:
  - Sample is discarded.
  - an_err is set.
  - No digit state changes.
- Valid sample for digit i: compare against the candidate cand_i.
  - If equal, count_i saturates-increments toward STABLE_CNT.
  - If different, cand_i takes the new code and count_i=1.
- Invalid pattern for digit i:
  - pat_err[i] is set.
  - count_i=0.
  - The committed bcd and valid are unchanged.
- Per-digit FSM:
  - EMPTY: no candidate. A valid sample goes to TRACK (or directly to LOCKED if STABLE_CNT=1).
  - TRACK: candidate accumulating.
    - When count_i reaches STABLE_CNT, commit: bcd_i=cand_i, valid[i]=1, next state LOCKED.
    - An invalid sample returns to EMPTY.
  - LOCKED: a matching sample stays in LOCKED. A differing valid sample goes to TRACK. An invalid sample goes to EMPTY. The committed value is held in all three cases.
- update:
  - High for exactly the one cycle after a commit that changes bcd_i or sets valid[i].
  - Re-committing the same value does not pulse.
  - Multiple digits cannot commit in the same cycle, because an is one-hot.
- Sticky flags and clr_err:
  - clr_err clears pat_err and an_err on the next edge.
  - If an error event and clr_err coincide, the error wins and the flag stays set.
- sample_en low: the stage-2 state holds.
- Reset mid-TRACK: the candidate is discarded. No update pulse is issued on the reset cycle or on the cycle after it.

Optional Feature:
- Macro: SEG7_CAP_ERRCNT_EN.
- When defined, the block adds an output err_cnt (8 bits).
  - It counts all invalid-pattern and anode-error qualified samples.
  - It saturates at 255.
  - It is cleared by rst or clr_err; if clr_err and an error coincide, the count becomes 1.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- After rst, drive an=4'b1110, led=0x24 with sample_en=1 for 3 cycles → one cycle later: bcd[3:0]=3, valid=4'b0001, update pulses once.
- Digit 2 locked at 7 (led=0xB4); then 2 samples of 0x20 followed by 0xB4 → bcd[11:8] stays 7, no update. Next, 3 samples of 0x20 → bcd[11:8]=9, update pulses.
- led=0xFE on an=4'b1101 → pat_err=4'b0010, bcd unchanged. Assert clr_err alone → pat_err=0.
- an=4'b1100 with led=0x10 and sample_en=1 → an_err=1, no valid or count change. an=4'b1111 → an_err=1 also.
- Round-robin scan of digits 0..3 showing 1,2,4,8 (0xB6, 0x44, 0xA2, 0x00), 3 frames each → bcd=16'h8421, valid=4'hF, exactly 4 update pulses. led[0] toggled randomly has no effect.
- With SEG7_CAP_ERRCNT_EN defined: 300 invalid samples → err_cnt=255. clr_err together with 1 error → err_cnt=1. Assert rst during TRACK → all outputs 0, no update pulse.
